// File: rtl/ifu_fetch.sv
// Fetch stage: owns the F-stage PC and runs a variable-latency imem req/ack handshake.
// Each fetched word (or an address-error entry) is offered to D over a valid/ready pair.
module ifu_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        D_ready,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic        F_adel,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic        adel_next;
    logic [31:0] cnt_next;
    logic        npc_bad;

    assign npc_bad = (npc[1:0] != 2'b00) || (npc < IMEM_LO) || (npc > IMEM_HI);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = F_instr;
        adel_next  = F_adel;
        cnt_next   = fetch_cnt;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    adel_next  = 1'b0;
                    state_next = VALID;
                end
            end
            VALID, ERR: begin
                // A handoff consumes npc; a bad target becomes an ERR entry instead of a request.
                if (D_ready) begin
                    cnt_next = fetch_cnt + 32'd1;
                    pc_next  = npc;
                    if (npc_bad) begin
                        state_next = ERR;
                        instr_next = 32'd0;
                        adel_next  = 1'b1;
                    end else begin
                        state_next = FETCH;
                        adel_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= PC_RESET;
            F_instr   <= 32'd0;
            F_adel    <= 1'b0;
            fetch_cnt <= 32'd0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            F_instr   <= instr_next;
            F_adel    <= adel_next;
            fetch_cnt <= cnt_next;
        end
    end

    assign imem_req  = reset && (state == FETCH);
    assign F_valid   = (state == VALID) || (state == ERR);
    assign imem_addr = pc;
    assign F_PC      = pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, a counter-wrap sequence and a
// randomized run checked against a behavioural model of the fetch rules.
module tb_ifu_fetch;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        D_ready;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic        F_valid;
    logic        F_adel;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifu_fetch #(
        .PC_RESET(PC_RESET),
        .IMEM_LO (IMEM_LO),
        .IMEM_HI (IMEM_HI)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .npc       (npc),
        .D_ready   (D_ready),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .F_PC      (F_PC),
        .F_instr   (F_instr),
        .F_valid   (F_valid),
        .F_adel    (F_adel),
        .fetch_cnt (fetch_cnt)
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        dr;
        logic [31:0] npc;
        logic        e_req;
        logic        e_valid;
        logic        e_adel;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: "is an entry on offer to D" plus what that entry holds.
    logic        m_valid;
    logic        m_adel;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic [31:0] rd,
                                 input logic dr, input logic [31:0] n);
        @(negedge clk);
        reset      = r;
        imem_ack   = a;
        imem_rdata = rd;
        D_ready    = dr;
        npc        = n;
        #1;
    endtask

    task automatic addVec(input logic rst, input logic ack, input logic [31:0] rdata, input logic dr,
                          input logic [31:0] n, input logic e_req, input logic e_valid, input logic e_adel,
                          input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.dr = dr; v.npc = n;
        v.e_req = e_req; v.e_valid = e_valid; v.e_adel = e_adel;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a < IMEM_LO) || (a > IMEM_HI);
    endfunction

    task automatic modelStep(input logic r, input logic a, input logic [31:0] rd,
                             input logic dr, input logic [31:0] n);
        if (!r) begin
            m_valid = 1'b0; m_adel = 1'b0; m_instr = 32'd0; m_pc = PC_RESET; m_cnt = 32'd0;
        end else if (!m_valid) begin
            if (a) begin
                m_valid = 1'b1; m_adel = 1'b0; m_instr = rd;
            end
        end else if (dr) begin
            m_cnt = m_cnt + 32'd1;
            m_pc  = n;
            if (is_bad(n)) begin
                m_valid = 1'b1; m_adel = 1'b1; m_instr = 32'd0;
            end else begin
                m_valid = 1'b0; m_adel = 1'b0;
            end
        end
    endtask

    task automatic checkState(input logic ev, input logic ea, input logic [31:0] epc,
                              input logic [31:0] ei, input logic [31:0] ec);
        checkOutput("F_valid", {31'd0, F_valid}, {31'd0, ev});
        checkOutput("F_adel", {31'd0, F_adel}, {31'd0, ea});
        checkOutput("F_PC", F_PC, epc);
        checkOutput("imem_addr", imem_addr, epc);
        checkOutput("fetch_cnt", fetch_cnt, ec);
        if (ev) checkOutput("F_instr", F_instr, ei);
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; D_ready = 1'b0; npc = 32'd0;

        //      rst ack rdata          dr npc            req vld adel pc             instr          cnt
        addVec(0, 0, 32'h0,          0, 32'h0,         0,  0,  0,  32'h3000, 32'h0,          0);
        addVec(1, 1, 32'h3C01_1234,  1, 32'h3004,      1,  1,  0,  32'h3000, 32'h3C01_1234,  0);
        addVec(1, 0, 32'h0,          1, 32'h3004,      0,  0,  0,  32'h3004, 32'h0,          1);
        addVec(1, 0, 32'h0,          1, 32'h3004,      1,  0,  0,  32'h3004, 32'h0,          1);
        addVec(1, 0, 32'h0,          1, 32'h3004,      1,  0,  0,  32'h3004, 32'h0,          1);
        addVec(1, 0, 32'h0,          1, 32'h3004,      1,  0,  0,  32'h3004, 32'h0,          1);
        addVec(1, 1, 32'h2401_0005,  0, 32'h3008,      1,  1,  0,  32'h3004, 32'h2401_0005,  1);
        addVec(1, 0, 32'h0,          0, 32'h4000,      0,  1,  0,  32'h3004, 32'h2401_0005,  1);
        addVec(1, 1, 32'hFFFF_0000,  0, 32'h3008,      0,  1,  0,  32'h3004, 32'h2401_0005,  1);
        addVec(1, 0, 32'h0,          0, 32'h4000,      0,  1,  0,  32'h3004, 32'h2401_0005,  1);
        addVec(1, 0, 32'h0,          0, 32'h3008,      0,  1,  0,  32'h3004, 32'h2401_0005,  1);
        addVec(1, 0, 32'h0,          1, 32'h4000,      0,  0,  0,  32'h4000, 32'h0,          2);
        addVec(1, 1, 32'h8C22_0000,  0, 32'h3002,      1,  1,  0,  32'h4000, 32'h8C22_0000,  2);
        addVec(1, 0, 32'h0,          1, 32'h3002,      0,  1,  1,  32'h3002, 32'h0,          3);
        addVec(1, 1, 32'h5555_5555,  1, 32'h7000,      0,  1,  1,  32'h7000, 32'h0,          4);
        addVec(1, 0, 32'h0,          1, 32'h3010,      0,  0,  0,  32'h3010, 32'h0,          5);
        addVec(1, 1, 32'h1234_5678,  0, 32'h0,         1,  1,  0,  32'h3010, 32'h1234_5678,  5);
        addVec(1, 0, 32'h0,          1, 32'h3020,      0,  0,  0,  32'h3020, 32'h0,          6);
        addVec(0, 1, 32'hDEAD_BEEF,  1, 32'h3040,      0,  0,  0,  32'h3000, 32'h0,          0);
        addVec(1, 0, 32'h0,          1, 32'h3040,      1,  0,  0,  32'h3000, 32'h0,          0);
        addVec(1, 1, 32'hCAFE_F00D,  0, 32'h0,         1,  1,  0,  32'h3000, 32'hCAFE_F00D,  0);
        addVec(1, 0, 32'h0,          1, 32'h6FFC,      0,  0,  0,  32'h6FFC, 32'h0,          1);
        addVec(1, 1, 32'h0000_0001,  0, 32'h0,         1,  1,  0,  32'h6FFC, 32'h0000_0001,  1);
        addVec(1, 0, 32'h0,          1, 32'h2FFC,      0,  1,  1,  32'h2FFC, 32'h0,          2);
        addVec(1, 0, 32'h0,          1, 32'h7001,      0,  1,  1,  32'h7001, 32'h0,          3);
        addVec(1, 0, 32'h0,          1, 32'h3000,      0,  0,  0,  32'h3000, 32'h0,          4);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].dr, vecs[i].npc);
            checkOutput($sformatf("vec%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            @(posedge clk); #1;
            checkState(vecs[i].e_valid, vecs[i].e_adel, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_cnt);
        end

        // Counter wrap: preload near the top, then two handoffs.
        applyStimulus(0, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        applyStimulus(1, 1, 32'h1111_1111, 0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        force dut.fetch_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_cnt;
        applyStimulus(1, 0, 32'h0, 1, 32'h3004);
        @(posedge clk); #1;
        checkOutput("wrap cnt FFFFFFFF", fetch_cnt, 32'hFFFF_FFFF);
        applyStimulus(1, 1, 32'h2222_2222, 0, 32'h0);
        @(posedge clk); #1;
        applyStimulus(1, 0, 32'h0, 1, 32'h3008);
        @(posedge clk); #1;
        checkOutput("wrap cnt 0", fetch_cnt, 32'h0);

        // Randomized run against the model, starting from reset.
        modelStep(0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 2000; k++) begin
            logic        r, a, dr;
            logic [31:0] rd, n;
            int          sel;
            r   = ($urandom_range(0, 49) != 0);
            a   = ($urandom_range(0, 9) < 4);
            dr  = ($urandom_range(0, 9) < 6);
            rd  = $urandom;
            sel = $urandom_range(0, 3);
            if (sel < 2)       n = IMEM_LO + 4 * $urandom_range(0, 32'hFFF);
            else if (sel == 2) n = IMEM_LO + 4 * $urandom_range(0, 32'hFFF) + $urandom_range(1, 3);
            else               n = $urandom & 32'hFFFF_FFFC;
            applyStimulus(r, a, rd, dr, n);
            checkOutput("rand imem_req", {31'd0, imem_req}, {31'd0, (r && !m_valid)});
            modelStep(r, a, rd, dr, n);
            @(posedge clk); #1;
            checkState(m_valid, m_adel, m_pc, m_instr, m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
